// File: rtl/control_merge_if.sv
// rtl/control_merge_if.sv - handshake bundle for the control_merge arbiter/fork
//
// Purpose: groups the SIZE merge inputs and the two forked outputs (data and
// winner index) of control_merge into one interface.
// Signals:
//   ins / ins_valid / ins_ready        SIZE flattened producer channels
//   outs / outs_valid / outs_ready     merged data channel
//   index / index_valid / index_ready  winner-index channel
// Modports:
//   slave  - the merge block (consumes ins, produces outs/index)
//   master - the surrounding environment
interface control_merge_if #(
    parameter int SIZE       = 2,
    parameter int DATA_TYPE  = 32,
    parameter int INDEX_TYPE = 1
);
    logic [SIZE*DATA_TYPE-1:0] ins;
    logic [SIZE-1:0]           ins_valid;
    logic [SIZE-1:0]           ins_ready;
    logic [DATA_TYPE-1:0]      outs;
    logic                      outs_valid;
    logic                      outs_ready;
    logic [INDEX_TYPE-1:0]     index;
    logic                      index_valid;
    logic                      index_ready;

    modport slave (
        input  ins, ins_valid, outs_ready, index_ready,
        output ins_ready, outs, outs_valid, index, index_valid
    );

    modport master (
        output ins, ins_valid, outs_ready, index_ready,
        input  ins_ready, outs, outs_valid, index, index_valid
    );
endinterface

// File: rtl/control_merge.sv
// rtl/control_merge.sv - fixed-priority merge with one-slot buffer and eager index fork
//
// Purpose: picks the lowest-numbered valid input, passes it through a
// transparent one-entry buffer, and forks the token eagerly to a data output
// and a winner-index output. Each side sees the token exactly once.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous reset, active-high
//   bus  - control_merge_if.slave (ins*, outs*, index* handshakes)
module control_merge #(
    parameter int SIZE       = 2,
    parameter int DATA_TYPE  = 32,
    parameter int INDEX_TYPE = 1
) (
    input  logic           clk,
    input  logic           rst,
    control_merge_if.slave bus
);

    logic                  full;
    logic [DATA_TYPE-1:0]  buf_data;
    logic [INDEX_TYPE-1:0] buf_idx;
    logic                  sent_out;
    logic                  sent_idx;

    logic                  any_v;
    logic [SIZE-1:0]       gnt;
    logic [DATA_TYPE-1:0]  m_data;
    logic [INDEX_TYPE-1:0] m_idx;

    logic                  t_valid;
    logic                  done_o;
    logic                  done_i;
    logic                  f_ready;

    // Descending scan so the lowest valid input is the last one written.
    always_comb begin
        gnt    = '0;
        m_data = '0;
        m_idx  = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (bus.ins_valid[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                m_data = bus.ins[i*DATA_TYPE +: DATA_TYPE];
                m_idx  = INDEX_TYPE'(i);
            end
        end
    end

    assign any_v   = |bus.ins_valid;
    assign t_valid = full | any_v;

    // Inputs are only acked while the buffer is empty; a draining buffer
    // still blocks them for that cycle.
    assign bus.ins_ready = full ? '0 : gnt;

    assign bus.outs        = full ? buf_data : m_data;
    assign bus.index       = full ? buf_idx  : m_idx;
    assign bus.outs_valid  = t_valid & ~sent_out;
    assign bus.index_valid = t_valid & ~sent_idx;

    // A side that already took the token counts as done until the other
    // side catches up.
    assign done_o  = sent_out | bus.outs_ready;
    assign done_i  = sent_idx | bus.index_ready;
    assign f_ready = done_o & done_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            sent_out <= 1'b0;
            sent_idx <= 1'b0;
        end else begin
            full     <= t_valid & ~f_ready;
            sent_out <= t_valid & ~f_ready & done_o;
            sent_idx <= t_valid & ~f_ready & done_i;
        end
        // Capture only a freshly accepted token that could not leave this
        // cycle; a held token is never overwritten.
        if (!full && any_v && !f_ready) begin
            buf_data <= m_data;
            buf_idx  <= m_idx;
        end
    end

endmodule

// File: tb/tb_control_merge.sv
// tb/tb_control_merge.sv - self-checking bench for control_merge
module tb_control_merge;
    localparam int SIZE       = 2;
    localparam int DATA_TYPE  = 8;
    localparam int INDEX_TYPE = 1;
    localparam int N_TOKENS   = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_merge_if #(.SIZE(SIZE), .DATA_TYPE(DATA_TYPE), .INDEX_TYPE(INDEX_TYPE)) bus ();

    control_merge #(.SIZE(SIZE), .DATA_TYPE(DATA_TYPE), .INDEX_TYPE(INDEX_TYPE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic ordy, input logic irdy);
        bus.ins_valid   = v;
        bus.ins         = {d1, d0};
        bus.outs_ready  = ordy;
        bus.index_ready = irdy;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [7:0] od,
                              input logic iv, input logic idx, input logic [1:0] rdy);
        @(negedge clk);
        check({tag, "_outs_valid"}, bus.outs_valid, ov);
        if (ov) check({tag, "_outs"}, bus.outs, od);
        check({tag, "_index_valid"}, bus.index_valid, iv);
        if (iv) check({tag, "_index"}, bus.index, idx);
        check({tag, "_ins_ready"}, bus.ins_ready, rdy);
    endtask

    // Random-phase reference model: an accepted token is queued once for
    // each consumer; a new token may enter only when nothing is outstanding.
    logic [7:0] hold_data [SIZE];
    bit         holding   [SIZE];
    logic [7:0] out_q [$];
    int         idx_q [$];
    int         accepted, got_out, got_idx, cyc, k;
    logic [1:0] exp_rdy;

    task automatic model_cycle(input string tag);
        @(negedge clk);
        exp_rdy = 2'b00;
        if (out_q.size() == 0 && idx_q.size() == 0) begin
            if (holding[0])      exp_rdy = 2'b01;
            else if (holding[1]) exp_rdy = 2'b10;
        end
        check({tag, "_ins_ready"}, bus.ins_ready, exp_rdy);
        if (exp_rdy != 2'b00) begin
            k = exp_rdy[1] ? 1 : 0;
            out_q.push_back(hold_data[k]);
            idx_q.push_back(k);
            holding[k] = 1'b0;
            accepted++;
        end
        check({tag, "_outs_valid"}, bus.outs_valid, out_q.size() != 0);
        if (out_q.size() != 0) begin
            check({tag, "_outs"}, bus.outs, out_q[0]);
            if (bus.outs_ready) begin
                void'(out_q.pop_front());
                got_out++;
            end
        end
        check({tag, "_index_valid"}, bus.index_valid, idx_q.size() != 0);
        if (idx_q.size() != 0) begin
            check({tag, "_index"}, bus.index, idx_q[0][0]);
            if (bus.index_ready) begin
                void'(idx_q.pop_front());
                got_idx++;
            end
        end
        adv();
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b1);
        adv();
        adv();
        rst = 1'b0;
        expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        adv();

        // Empty buffer, both ready: same-cycle pass-through.
        drive(2'b01, 8'hA5, 8'h00, 1'b1, 1'b1);
        expect_out("t1", 1'b1, 8'hA5, 1'b1, 1'b0, 2'b01);
        adv();

        // Two valids: input 0 wins, input 1 is served after input 0 drops.
        drive(2'b11, 8'h11, 8'h22, 1'b1, 1'b1);
        expect_out("t2a", 1'b1, 8'h11, 1'b1, 1'b0, 2'b01);
        adv();
        drive(2'b10, 8'h11, 8'h22, 1'b1, 1'b1);
        expect_out("t2b", 1'b1, 8'h22, 1'b1, 1'b1, 2'b10);
        adv();

        // Data side stalls; index taken once, token held, inputs blocked.
        drive(2'b01, 8'h33, 8'h00, 1'b0, 1'b1);
        expect_out("t3a", 1'b1, 8'h33, 1'b1, 1'b0, 2'b01);
        adv();
        drive(2'b01, 8'h55, 8'h00, 1'b0, 1'b1);
        expect_out("t3b", 1'b1, 8'h33, 1'b0, 1'b0, 2'b00);
        adv();
        expect_out("t3c", 1'b1, 8'h33, 1'b0, 1'b0, 2'b00);
        adv();
        drive(2'b01, 8'h55, 8'h00, 1'b1, 1'b1);
        expect_out("t3d", 1'b1, 8'h33, 1'b0, 1'b0, 2'b00);
        adv();
        expect_out("t3e", 1'b1, 8'h55, 1'b1, 1'b0, 2'b01);
        adv();

        // Index side stalls 3 cycles; data taken once.
        drive(2'b10, 8'h00, 8'h44, 1'b1, 1'b0);
        expect_out("t4a", 1'b1, 8'h44, 1'b1, 1'b1, 2'b10);
        adv();
        drive(2'b00, 8'h00, 8'h44, 1'b1, 1'b0);
        expect_out("t4b", 1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
        adv();
        expect_out("t4c", 1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
        adv();
        drive(2'b00, 8'h00, 8'h44, 1'b1, 1'b1);
        expect_out("t4d", 1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
        adv();
        expect_out("t4e", 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        adv();

        // Reset while full with the data side already served.
        drive(2'b01, 8'h66, 8'h00, 1'b1, 1'b0);
        expect_out("t5a", 1'b1, 8'h66, 1'b1, 1'b0, 2'b01);
        adv();
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        adv();
        rst = 1'b0;
        expect_out("t5b", 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        drive(2'b10, 8'h00, 8'h77, 1'b1, 1'b1);
        expect_out("t5c", 1'b1, 8'h77, 1'b1, 1'b1, 2'b10);
        adv();
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b1);
        adv();

        // Random traffic against the queue model.
        accepted = 0; got_out = 0; got_idx = 0; cyc = 0;
        for (int i = 0; i < SIZE; i++) begin
            holding[i]   = 1'b0;
            hold_data[i] = 8'h00;
        end
        while (accepted < N_TOKENS && cyc < 30000) begin
            for (int i = 0; i < SIZE; i++) begin
                if (!holding[i] && $urandom_range(2) != 0) begin
                    holding[i]   = 1'b1;
                    hold_data[i] = 8'($urandom);
                end
            end
            drive({holding[1], holding[0]}, hold_data[0], hold_data[1],
                  $urandom_range(3) != 0, $urandom_range(3) != 0);
            model_cycle("rnd");
            cyc++;
        end
        check("rnd_accept_budget", accepted, N_TOKENS);

        for (int i = 0; i < SIZE; i++) holding[i] = 1'b0;
        cyc = 0;
        while ((out_q.size() != 0 || idx_q.size() != 0) && cyc < 10) begin
            drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b1);
            model_cycle("drain");
            cyc++;
        end
        check("drain_out_q_empty", out_q.size(), 0);
        check("drain_idx_q_empty", idx_q.size(), 0);
        check("delivered_outs", got_out, accepted);
        check("delivered_index", got_idx, accepted);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
